// File: rtl/breakout_game_sequencer.sv
// breakout_game_sequencer
// Game-level controller for the breakout display path. Moves a round through
// idle, serve, play, miss-freeze, game-over and win phases. Tracks the bricks
// remaining, the lives and a two-digit BCD score. Drives the ball-motion
// enable and the ball/grid re-initialise strobes.
//
// Parameters:
//   NUM_BRICKS   bricks in a full grid (1..127)
//   LIVES_INIT   lives at the start of a game (1..15)
//   SERVE_TICKS  frame ticks the ball is held before an automatic serve
//   MISS_TICKS   frame ticks of freeze after a floor hit
// Ports:
//   clk          game clock, all logic on the rising edge
//   rst          synchronous active-low reset
//   frame_tick   one pulse per displayed frame, times the tick counter
//   start        debounced single-cycle button pulse
//   brick_hit    one pulse per newly destroyed brick
//   floor_hit    one pulse when the ball reaches the floor
//   state        current phase (IDLE=0 SERVE=1 PLAY=2 MISS=3 OVER=4 WIN=5)
//   ball_run     high only in PLAY; gates ball movement
//   ball_reload  one-cycle strobe to recentre the ball above the paddle
//   grid_reload  one-cycle strobe to mark every brick un-hit
//   bricks_left  bricks remaining
//   lives        lives remaining
//   score_ones   BCD ones digit of the score
//   score_tens   BCD tens digit of the score
module breakout_game_sequencer #(
    parameter int NUM_BRICKS  = 60,
    parameter int LIVES_INIT  = 9,
    parameter int SERVE_TICKS = 60,
    parameter int MISS_TICKS  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       brick_hit,
    input  logic       floor_hit,
    output logic [2:0] state,
    output logic       ball_run,
    output logic       ball_reload,
    output logic       grid_reload,
    output logic [6:0] bricks_left,
    output logic [3:0] lives,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        MISS  = 3'd3,
        OVER  = 3'd4,
        WIN   = 3'd5
    } phase_t;

    // One counter serves both SERVE and MISS, so it is sized for the longer one.
    localparam int MAX_TICKS = (SERVE_TICKS > MISS_TICKS) ? SERVE_TICKS : MISS_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_TICKS - 1);
    localparam logic [6:0] BRICKS_FULL = 7'(NUM_BRICKS);
    localparam logic [3:0] LIVES_FULL  = 4'(LIVES_INIT);

    phase_t           cur, nxt;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [6:0]       bricks_n;
    logic [3:0]       lives_n, ones_n, tens_n;
    logic             ball_run_n, ball_reload_n, grid_reload_n;

    assign state = cur;

    // State and every output are registered; the reset returns all of them to
    // their start-of-power values without emitting any strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur         <= IDLE;
            cnt         <= '0;
            bricks_left <= BRICKS_FULL;
            lives       <= LIVES_FULL;
            score_ones  <= 4'd0;
            score_tens  <= 4'd0;
            ball_run    <= 1'b0;
            ball_reload <= 1'b0;
            grid_reload <= 1'b0;
        end else begin
            cur         <= nxt;
            cnt         <= cnt_n;
            bricks_left <= bricks_n;
            lives       <= lives_n;
            score_ones  <= ones_n;
            score_tens  <= tens_n;
            ball_run    <= ball_run_n;
            ball_reload <= ball_reload_n;
            grid_reload <= grid_reload_n;
        end
    end

    // Next-state and next-output logic. ball_run follows the next state so it
    // drops on the very edge that the state leaves PLAY.
    always_comb begin
        nxt           = cur;
        cnt_n         = cnt;
        bricks_n      = bricks_left;
        lives_n       = lives;
        ones_n        = score_ones;
        tens_n        = score_tens;
        ball_reload_n = 1'b0;
        grid_reload_n = 1'b0;

        case (cur)
            IDLE, OVER, WIN: begin
                if (start) begin
                    nxt           = SERVE;
                    cnt_n         = '0;
                    bricks_n      = BRICKS_FULL;
                    lives_n       = LIVES_FULL;
                    ones_n        = 4'd0;
                    tens_n        = 4'd0;
                    ball_reload_n = 1'b1;
                    grid_reload_n = 1'b1;
                end
            end
            SERVE: begin
                if (start) begin
                    nxt   = PLAY;
                    cnt_n = '0;
                end else if (frame_tick) begin
                    if (cnt == SERVE_LAST) begin
                        nxt   = PLAY;
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            PLAY: begin
                // The brick is scored first; clearing the grid wins over a
                // coincident floor hit, which then costs no life.
                if (brick_hit && bricks_left != 7'd0) begin
                    bricks_n = bricks_left - 7'd1;
                    if (!(score_tens == 4'd9 && score_ones == 4'd9)) begin
                        if (score_ones == 4'd9) begin
                            ones_n = 4'd0;
                            tens_n = score_tens + 4'd1;
                        end else begin
                            ones_n = score_ones + 4'd1;
                        end
                    end
                    if (bricks_left == 7'd1) begin
                        nxt = WIN;
                    end
                end
                if (nxt != WIN && floor_hit && lives != 4'd0) begin
                    lives_n = lives - 4'd1;
                    nxt     = (lives == 4'd1) ? OVER : MISS;
                end
            end
            MISS: begin
                if (frame_tick) begin
                    if (cnt == MISS_LAST) begin
                        nxt           = SERVE;
                        cnt_n         = '0;
                        ball_reload_n = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                nxt = IDLE;
            end
        endcase

        ball_run_n = (nxt == PLAY);
    end

endmodule

// File: tb/tb_breakout_game_sequencer.sv
// tb_breakout_game_sequencer
// Self-checking bench for breakout_game_sequencer. A behavioural model of the
// game rules (integer score, ticks-seen counts) predicts every output after
// each clock edge. Directed phases walk the documented scenarios and a
// randomized phase exercises arbitrary input mixes.
module tb_breakout_game_sequencer;

    localparam int NB = 127;
    localparam int LI = 9;
    localparam int ST = 60;
    localparam int MT = 30;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_MISS  = 3;
    localparam int P_OVER  = 4;
    localparam int P_WIN   = 5;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       start;
    logic       brick_hit;
    logic       floor_hit;
    logic [2:0] state;
    logic       ball_run;
    logic       ball_reload;
    logic       grid_reload;
    logic [6:0] bricks_left;
    logic [3:0] lives;
    logic [3:0] score_ones;
    logic [3:0] score_tens;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_phase  = P_IDLE;
    int m_ticks  = 0;
    int m_bricks = NB;
    int m_lives  = LI;
    int m_score  = 0;
    int m_ball_reload = 0;
    int m_grid_reload = 0;

    breakout_game_sequencer #(
        .NUM_BRICKS (NB),
        .LIVES_INIT (LI),
        .SERVE_TICKS(ST),
        .MISS_TICKS (MT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .brick_hit  (brick_hit),
        .floor_hit  (floor_hit),
        .state      (state),
        .ball_run   (ball_run),
        .ball_reload(ball_reload),
        .grid_reload(grid_reload),
        .bricks_left(bricks_left),
        .lives      (lives),
        .score_ones (score_ones),
        .score_tens (score_tens)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Game rules applied once per clock edge with the sampled inputs.
    task automatic modelStep(input int r, input int ft, input int st, input int bh, input int fh);
        m_ball_reload = 0;
        m_grid_reload = 0;
        if (r == 0) begin
            m_phase  = P_IDLE;
            m_ticks  = 0;
            m_bricks = NB;
            m_lives  = LI;
            m_score  = 0;
        end else begin
            case (m_phase)
                P_IDLE, P_OVER, P_WIN: begin
                    if (st != 0) begin
                        m_phase  = P_SERVE;
                        m_ticks  = 0;
                        m_bricks = NB;
                        m_lives  = LI;
                        m_score  = 0;
                        m_ball_reload = 1;
                        m_grid_reload = 1;
                    end
                end
                P_SERVE: begin
                    if (st != 0) begin
                        m_phase = P_PLAY;
                        m_ticks = 0;
                    end else if (ft != 0) begin
                        m_ticks++;
                        if (m_ticks == ST) begin
                            m_phase = P_PLAY;
                            m_ticks = 0;
                        end
                    end
                end
                P_PLAY: begin
                    if (bh != 0 && m_bricks > 0) begin
                        m_bricks--;
                        if (m_score < 99) m_score++;
                        if (m_bricks == 0) m_phase = P_WIN;
                    end
                    if (m_phase == P_PLAY && fh != 0 && m_lives > 0) begin
                        m_lives--;
                        m_phase = (m_lives == 0) ? P_OVER : P_MISS;
                    end
                end
                P_MISS: begin
                    if (ft != 0) begin
                        m_ticks++;
                        if (m_ticks == MT) begin
                            m_phase = P_SERVE;
                            m_ticks = 0;
                            m_ball_reload = 1;
                        end
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    task automatic checkAll();
        checkOutput("state",       int'(state),       m_phase);
        checkOutput("ball_run",    int'(ball_run),    (m_phase == P_PLAY) ? 1 : 0);
        checkOutput("ball_reload", int'(ball_reload), m_ball_reload);
        checkOutput("grid_reload", int'(grid_reload), m_grid_reload);
        checkOutput("bricks_left", int'(bricks_left), m_bricks);
        checkOutput("lives",       int'(lives),       m_lives);
        checkOutput("score_ones",  int'(score_ones),  m_score % 10);
        checkOutput("score_tens",  int'(score_tens),  m_score / 10);
    endtask

    // Drive one cycle of inputs, clock it, advance the model, then check.
    task automatic applyStimulus(input int r, input int ft, input int st, input int bh, input int fh);
        @(negedge clk);
        rst        = (r  != 0);
        frame_tick = (ft != 0);
        start      = (st != 0);
        brick_hit  = (bh != 0);
        floor_hit  = (fh != 0);
        @(posedge clk);
        modelStep(r, ft, st, bh, fh);
        #1;
        checkAll();
    endtask

    initial begin
        rst        = 1'b0;
        frame_tick = 1'b0;
        start      = 1'b0;
        brick_hit  = 1'b0;
        floor_hit  = 1'b0;

        $display("[TB] reset and idle");
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 1, 1);

        $display("[TB] start into serve");
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("start_state", int'(state), P_SERVE);
        checkOutput("start_grid_reload", int'(grid_reload), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("strobe_one_cycle", int'(ball_reload), 0);

        $display("[TB] automatic serve after frame ticks");
        for (int i = 0; i < ST; i++) begin
            applyStimulus(1, 1, 0, 0, 0);
            applyStimulus(1, 0, 0, 0, 0);
        end
        checkOutput("auto_serve_run", int'(ball_run), 1);

        $display("[TB] twelve brick hits");
        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 1, 0);
        checkOutput("score12_tens", int'(score_tens), 1);
        checkOutput("score12_ones", int'(score_ones), 2);

        $display("[TB] floor hits down to game over");
        for (int k = 1; k <= LI; k++) begin
            applyStimulus(1, 0, 0, 0, 1);
            checkOutput("miss_lives", int'(lives), LI - k);
            if (k < LI) begin
                for (int t = 0; t < MT; t++) begin
                    applyStimulus(1, 0, (t == 3) ? 1 : 0, 0, 0);
                    applyStimulus(1, 1, 0, 0, 0);
                end
                applyStimulus(1, 0, 1, 0, 0);
            end
        end
        checkOutput("over_state", int'(state), P_OVER);
        applyStimulus(1, 0, 1, 0, 0);
        checkOutput("restart_lives", int'(lives), LI);

        $display("[TB] randomized play");
        applyStimulus(1, 0, 1, 0, 0);
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0) ? 0 : 1,
                          ($urandom_range(0, 2) == 0) ? 1 : 0,
                          ($urandom_range(0, 29) == 0) ? 1 : 0,
                          ($urandom_range(0, 2) == 0) ? 1 : 0,
                          ($urandom_range(0, 39) == 0) ? 1 : 0);
        end

        $display("[TB] score saturation and win priority");
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0);
        for (int i = 0; i < NB - 1; i++) applyStimulus(1, 0, 0, 1, 0);
        checkOutput("sat_ones", int'(score_ones), 9);
        checkOutput("sat_tens", int'(score_tens), 9);
        applyStimulus(1, 0, 0, 1, 1);
        checkOutput("win_state", int'(state), P_WIN);
        checkOutput("win_lives", int'(lives), LI);
        checkOutput("win_bricks", int'(bricks_left), 0);
        applyStimulus(1, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(1, 0, 1, 0, 0);

        $display("[TB] reset during miss freeze");
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        for (int t = 0; t < 15; t++) begin
            applyStimulus(1, 1, 0, 0, 0);
            applyStimulus(1, 0, 0, 0, 0);
        end
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("rst_state", int'(state), P_IDLE);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/breakout_game_sequencer.md
# breakout_game_sequencer

Game-level controller for the breakout display path. Sequences a round through idle, serve, play, miss-freeze, game-over and win phases. Counts bricks remaining, lives and a two-digit BCD score. Drives the ball-motion enable and the ball/grid re-initialise strobes consumed by the block/ball controller, and feeds the score and lives digits to the seven-segment path.

## Interface
- `NUM_BRICKS`, 60: bricks in a full grid (5 rows x 12 columns); range 1..127.
- `LIVES_INIT`, 9: lives at start of game; range 1..15.
- `SERVE_TICKS`, 60: frame ticks the ball is held before an automatic serve.
- `MISS_TICKS`, 30: frame ticks of freeze after a floor hit.
- `clk`  input  1: game clock; all logic on rising edge.
- `rst`  input  1: synchronous, active-low reset (sampled on `clk`; 0 = reset).
- `frame_tick`  input  1: one-cycle pulse per displayed frame; times all tick counters.
- `start`  input  1: debounced single-cycle button pulse.
- `brick_hit`  input  1: one-cycle pulse, one per newly destroyed brick.
- `floor_hit`  input  1: one-cycle pulse, ball reached floor.
- `state`  output  3: current phase; IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, WIN=5.
- `ball_run`  output  1: 1 only in PLAY; ball position updates gated by it.
- `ball_reload`  output  1: one-cycle strobe; recentre ball above paddle.
- `grid_reload`  output  1: one-cycle strobe; mark all bricks un-hit.
- `bricks_left`  output  7: bricks remaining.
- `lives`  output  4: lives remaining.
- `score_ones`, `score_tens`  output  4 each: BCD score digits.

## Operation
- All outputs registered. Reset values: `state`=IDLE, `ball_run`=0, `ball_reload`=0, `grid_reload`=0, `bricks_left`=NUM_BRICKS, `lives`=LIVES_INIT, score=00, tick counter=0.
- IDLE: hold. On `start`, go to SERVE. In the same edge:
  - pulse `ball_reload` and `grid_reload`;
  - reload lives, bricks and score to their reset values.
- SERVE: ball held. Tick counter increments on each `frame_tick`. Go to PLAY when either `start` occurs or the counter reaches SERVE_TICKS-1 with a `frame_tick`. Counter clears on exit.
- PLAY: `ball_run`=1.
  - `brick_hit`: `bricks_left` decrements. Score increments in BCD: ones 9 rolls to 0 and carries to tens. Score saturates at 99 (stays 99 on further hits).
  - If the decrement takes `bricks_left` to 0, go to WIN.
  - Otherwise, on `floor_hit`: `lives` decrements. If the new value is 0, go to OVER. If not, go to MISS.
  - `brick_hit` and `floor_hit` on the same edge: the brick is counted first. WIN has priority over the floor hit; in that case `lives` is not decremented.
  - `brick_hit` or `floor_hit` while `bricks_left` is already 0 or outside PLAY: ignored. Counters never underflow.
- MISS: `ball_run`=0. Counts MISS_TICKS frame ticks. On the last tick, pulse `ball_reload` and go to SERVE.
- OVER and WIN: `ball_run`=0 and counters frozen. `start` behaves exactly as in IDLE: reload everything and go to SERVE.
- `start` in PLAY or MISS: ignored.
- Strobes are high for exactly one cycle and never asserted in two consecutive cycles.

## Timing
- Single clock. Every input is acted on at the first rising edge where it is sampled high. Outputs change one edge later.
- `ball_run` falls on the same edge at which `state` leaves PLAY. The ball therefore moves at most zero positions after the terminal event is registered.
- SERVE duration with no `start`: exactly SERVE_TICKS frame ticks.
- MISS duration: exactly MISS_TICKS frame ticks.
- A `frame_tick` coincident with a state entry does not count toward the new state's counter.
- Reset asserted mid-game: on the next edge all outputs return to reset values. No strobe is emitted.

## Test plan
- Reset, then `start` -> `state`=SERVE next cycle. `ball_reload` and `grid_reload` each high exactly 1 cycle. `lives`=9, score 00, `bricks_left`=60.
- In SERVE, 60 `frame_tick` pulses with no `start` -> PLAY after the 60th. `ball_run`=1 from that edge.
- In PLAY, 12 `brick_hit` pulses -> score 1/2 (tens/ones), `bricks_left`=48. With NUM_BRICKS=127, 105 hits -> score saturates at 99.
- Nine `floor_hit` pulses, each followed by 30 ticks and a serve:
  - lives count 8..1 through MISS;
  - the 9th hit gives `lives`=0 and `state`=OVER;
  - `start` then restores `lives`=9 and enters SERVE.
- `bricks_left`=1 with `brick_hit` and `floor_hit` on the same edge -> `state`=WIN, `lives` unchanged, `bricks_left`=0. A further `brick_hit` is ignored.
- `rst`=0 for one cycle while in MISS with counter at 15 -> IDLE, all outputs at reset values. A `frame_tick` in IDLE causes no change.
